// File: rtl/ltl_symbol_sequencer.sv
// Purpose : packs per-cycle event predicate bits into 8-bit symbols and streams them to a cluster of
//           Automata_* monitors with the reset/start-of-data sequence, latching monitor reports.
// Latency : push->mon_run 1 cycle in STREAM; first symbol of a session no earlier than RST_CYCLES+1 after enable.
// Backpr. : none upstream; events arriving with the FIFO full (and no pop that cycle) are dropped and flagged.
//
// Ports:
//   clk, reset (async, active-high)   : clock and reset
//   enable                            : session level (1 = run/continue, 0 = end)
//   ev_valid, ev_bits[7:0]            : event sample in; ev_bits becomes the symbol unchanged
//   mon_reports[NUM_REPORTS-1:0]      : report lines back from the monitors
//   symbols[7:0], mon_run, mon_reset  : monitor-side symbol stream and control
//   report_sticky, report_first       : sticky report flags; lowest index of first report (MSB = valid)
//   sym_count[31:0], overflow, busy   : session symbol count (saturating), sticky drop flag, not-idle
//
// Optional feature: define LTL_SEQ_DEDUP_EN to suppress events whose bits repeat the last pushed value.
// NUM_REPORTS must be at least 2 so report_first has a non-empty index field.
module ltl_symbol_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int RST_CYCLES  = 2,
  parameter int NUM_REPORTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         ev_valid,
  input  logic [7:0]                   ev_bits,
  input  logic [NUM_REPORTS-1:0]       mon_reports,
  output logic [7:0]                   symbols,
  output logic                         mon_run,
  output logic                         mon_reset,
  output logic [NUM_REPORTS-1:0]       report_sticky,
  output logic [$clog2(NUM_REPORTS):0] report_first,
  output logic [31:0]                  sym_count,
  output logic                         overflow,
  output logic                         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int IW = $clog2(NUM_REPORTS);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_MIN = HW'(RST_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t        state;

  // Symbol FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [7:0]    head;
  logic          fifo_empty;
  logic          fifo_full;

  logic [HW-1:0] hold_cnt;
  logic          hold_ok;
  logic          rep_cap;

  logic          dup;
  logic          flush;
  logic          push_req;
  logic          push_en;
  logic          pop_en;
  logic          drop;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign hold_ok    = (hold_cnt >= HOLD_MIN);

`ifdef LTL_SEQ_DEDUP_EN
  logic [7:0] last_bits;
  logic       last_vld;

  // last_vld is cleared at session start so the first event of a session always goes through.
  assign dup = last_vld && (ev_bits == last_bits);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_bits <= 8'h00;
      last_vld  <= 1'b0;
    end else if (state == IDLE && enable) begin
      last_vld  <= 1'b0;
    end else if (push_en) begin
      last_bits <= ev_bits;
      last_vld  <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Leaving ARM early discards whatever was queued for the aborted session.
  assign flush    = (state == ARM) && !enable;
  assign push_req = ev_valid && ((state == ARM) || (state == STREAM)) && !dup && !flush;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign push_en  = push_req && (!fifo_full || pop_en);
  assign drop     = push_req && fifo_full && !pop_en;

  // The ARM->STREAM transition pops on the same edge, so the first symbol lands with mon_reset falling.
  always_comb begin
    pop_en = 1'b0;
    case (state)
      ARM:           pop_en = enable && hold_ok && !fifo_empty;
      STREAM, DRAIN: pop_en = !fifo_empty;
      default:       pop_en = 1'b0;
    endcase
  end

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_REPORTS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IW'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= ev_bits;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mon_reset     <= 1'b1;
      mon_run       <= 1'b0;
      symbols       <= 8'h00;
      report_sticky <= '0;
      report_first  <= '0;
      sym_count     <= 32'd0;
      overflow      <= 1'b0;
      busy          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      hold_cnt      <= '0;
      rep_cap       <= 1'b0;
    end else begin
      mon_run <= pop_en;
      if (pop_en) begin
        symbols <= head;
        rd_ptr  <= rd_ptr + PTR_ONE;
        if (sym_count != 32'hFFFF_FFFF) sym_count <= sym_count + 32'd1;
      end
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;

      // Monitor STEs register the symbol, so reports answer the cycle after mon_run.
      rep_cap <= mon_run;
      if (rep_cap) begin
        report_sticky <= report_sticky | mon_reports;
        if (!report_first[IW] && (|mon_reports)) begin
          report_first <= {1'b1, lowest_idx(mon_reports)};
        end
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state         <= ARM;
            busy          <= 1'b1;
            mon_reset     <= 1'b1;
            hold_cnt      <= HOLD_ONE;
            report_sticky <= '0;
            report_first  <= '0;
            sym_count     <= 32'd0;
            overflow      <= 1'b0;
            rep_cap       <= 1'b0;
          end
        end
        ARM: begin
          if (!enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
          end else begin
            if (!hold_ok) hold_cnt <= hold_cnt + HOLD_ONE;
            if (hold_ok && !fifo_empty) begin
              state     <= STREAM;
              mon_reset <= 1'b0;
            end
          end
        end
        STREAM: begin
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mon_reset <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mon_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
